// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet ingress buffer.
package eth_pkg;

  // Default frame word width; word_t below is sized to this.
  localparam int unsigned DataW = 32;

  // Width of the saturating frame counters.
  localparam int unsigned CntW = 16;

  // One buffered word with its frame markers.
  typedef struct packed {
    logic [DataW-1:0] data;
    logic             sop;
    logic             eop;
  } word_t;

  // Write-side frame reception state.
  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDiscard
  } wr_state_e;

endpackage

// File: rtl/eth_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-cycle write to the read address is forwarded so the read
// register never holds a stale copy of a freshly written word.
module eth_buf_ram #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 64,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read with write-first forwarding.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i == raddr_i)) rdata_o <= wdata_i;
    else                              rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/eth_ingress_buffer.sv
// Store-and-forward ingress buffer: frames are written into a circular RAM
// and released to the switch only once complete and within length limits.
module eth_ingress_buffer
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W    = DataW,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned MIN_WORDS = 2,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              drop_pulse,
  output logic [CntW-1:0]   frames_ok,
  output logic [CntW-1:0]   frames_dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(MAX_WORDS + 2);

  wr_state_e         state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     len_q, len_d;
  logic [CntW-1:0]   frames_ok_q, frames_dropped_q;
  logic              drop_pulse_q;

  logic [PW-1:0]     base;
  logic [LW-1:0]     len_nxt;
  logic              full;
  logic              we;
  logic              drop;
  logic              commit;
  logic              rd_xfer;
  word_t             wr_word;
  word_t             rd_word;

  // Write FSM: place words, check length at eop, rewind on any discard.
  // A truncation drop and a drop of the new frame in the same cycle
  // collapse into a single drop event.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    we           = 1'b0;
    drop         = 1'b0;
    commit       = 1'b0;
    // A new sop always restarts from the last committed position.
    base         = ((state_q == StRecv) && !in_sop) ? wr_ptr_q : commit_ptr_q;
    len_nxt      = (in_sop ? '0 : len_q) + LW'(1);
    // Conservative: uses rd_ptr before any read in this cycle.
    full         = (base - rd_ptr_q) == PW'(DEPTH);
    if (in_valid) begin
      if ((state_q == StRecv) && in_sop) begin
        drop     = 1'b1;
        wr_ptr_d = commit_ptr_q;
      end
      if (in_sop || (state_q == StRecv)) begin
        if ((len_nxt > LW'(MAX_WORDS)) || full) begin
          drop     = 1'b1;
          wr_ptr_d = commit_ptr_q;
          state_d  = in_eop ? StIdle : StDiscard;
        end else begin
          we       = 1'b1;
          wr_ptr_d = base + PW'(1);
          len_d    = len_nxt;
          if (in_eop) begin
            state_d = StIdle;
            if (len_nxt >= LW'(MIN_WORDS)) begin
              commit       = 1'b1;
              commit_ptr_d = base + PW'(1);
            end else begin
              drop     = 1'b1;
              wr_ptr_d = commit_ptr_q;
            end
          end else begin
            state_d = StRecv;
          end
        end
      end else if ((state_q == StDiscard) && in_eop) begin
        state_d = StIdle;
      end
    end
  end

  // Read pointer advances on each accepted output word.
  always_comb begin
    out_valid = rd_ptr_q != commit_ptr_q;
    rd_xfer   = out_valid && out_ready;
    rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, rd_xfer};
  end

  // State, pointers, counters and drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      wr_ptr_q         <= '0;
      commit_ptr_q     <= '0;
      rd_ptr_q         <= '0;
      len_q            <= '0;
      frames_ok_q      <= '0;
      frames_dropped_q <= '0;
      drop_pulse_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      drop_pulse_q <= drop;
      if (commit && (frames_ok_q != '1)) frames_ok_q <= frames_ok_q + 1'b1;
      if (drop && (frames_dropped_q != '1)) frames_dropped_q <= frames_dropped_q + 1'b1;
    end
  end

  // Pack the incoming word with its markers.
  always_comb begin
    wr_word.data = in_data;
    wr_word.sop  = in_sop;
    wr_word.eop  = in_eop;
  end

  // The read port always fetches the word at the post-transfer pointer,
  // so the register holds the head word (fall-through) and stays put
  // while the switch stalls.
  eth_buf_ram #(
    .Width ($bits(word_t)),
    .Depth (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (base[AW-1:0]),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (rd_word)
  );

  // Outputs are forced low when nothing committed is available.
  always_comb begin
    out_data       = out_valid ? rd_word.data : '0;
    out_sop        = out_valid & rd_word.sop;
    out_eop        = out_valid & rd_word.eop;
    drop_pulse     = drop_pulse_q;
    frames_ok      = frames_ok_q;
    frames_dropped = frames_dropped_q;
  end

endmodule

// File: tb/tb_eth_ingress_buffer.sv
// Scoreboard bench for eth_ingress_buffer: stimulus pushes expected output
// words, a negedge monitor pops and compares every transferred word.
module tb_eth_ingress_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        drop_pulse;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;

  logic [33:0] exp_q[$];
  int checks    = 0;
  int errors    = 0;
  int drop_seen = 0;
  int exp_ok    = 0;
  int exp_drop  = 0;

  always #5 clk = ~clk;

  eth_ingress_buffer #(
    .DATA_W    (32),
    .DEPTH     (64),
    .MIN_WORDS (2),
    .MAX_WORDS (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .drop_pulse     (drop_pulse),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts drop pulses, checks stall stability, pops the scoreboard.
  initial begin
    logic        prev_hold;
    logic [33:0] prev_word;
    logic [33:0] cur;
    logic [33:0] expw;
    prev_hold = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge clk);
      cur = {out_data, out_sop, out_eop};
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (drop_pulse) drop_seen++;
        if (prev_hold) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_word", 64'(cur), 64'(prev_word));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", cur);
          end else begin
            expw = exp_q.pop_front();
            check("out_word", 64'(cur), 64'(expw));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_word = cur;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic s, input logic e);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] first, input int n, input bit good);
    for (int i = 0; i < n; i++) begin
      if (good) exp_q.push_back({first + 32'(i), i == 0, i == n - 1});
      send_word(first + 32'(i), i == 0, i == n - 1);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {62'd0, exp_q.size() == 0, out_valid}, 64'b10);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_ok"}, 64'(frames_ok), 64'(exp_ok));
    check({name, "_dropped"}, 64'(frames_dropped), 64'(exp_drop));
    check({name, "_pulses"}, 64'(drop_seen), 64'(exp_drop));
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_data"}, 64'(out_data), 64'd0);
    check({name, "_sop"}, 64'(out_sop), 64'd0);
    check({name, "_eop"}, 64'(out_eop), 64'd0);
    check({name, "_drop"}, 64'(drop_pulse), 64'd0);
    check({name, "_ok"}, 64'(frames_ok), 64'd0);
    check({name, "_dropped"}, 64'(frames_dropped), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Single 4-word frame; visible one cycle after eop.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'h1111_0001 + 32'(i), i == 0, 1'b0});
      send_word(32'h1111_0001 + 32'(i), i == 0, 1'b0);
    end
    check("pre_eop_valid", 64'(out_valid), 64'd0);
    exp_q.push_back({32'h1111_0004, 1'b0, 1'b1});
    send_word(32'h1111_0004, 1'b0, 1'b1);
    check("eop_latency_valid", 64'(out_valid), 64'd1);
    check("eop_latency_sop", 64'(out_sop), 64'd1);
    exp_ok++;
    drain("single_drain");
    check_counts("single");

    // Runt single-word frame, then a legal 2-word frame.
    send_frame(32'h2222_0001, 1, 1'b0);
    exp_drop++;
    check("runt_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("runt_no_valid2", 64'(out_valid), 64'd0);
    send_frame(32'h2222_0010, 2, 1'b1);
    exp_ok++;
    drain("runt_drain");
    check_counts("runt");

    // Oversize: 20 words, drop on word 17, then a full 16-word frame.
    send_frame(32'h3333_0001, 20, 1'b0);
    exp_drop++;
    send_frame(32'h3333_0100, 16, 1'b1);
    exp_ok++;
    drain("oversize_drain");
    check_counts("oversize");

    // Overflow: five 16-word frames with the switch stalled.
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(32'h4444_0000 + 32'(f * 256), 16, f < 4);
    exp_ok   += 4;
    exp_drop += 1;
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_head", {30'd0, out_data, out_sop, out_eop}, {30'd0, 32'h4444_0000, 2'b10});
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("overflow_drain");
    check_counts("overflow");

    // Truncation: sop mid-frame aborts the first frame.
    for (int i = 0; i < 3; i++) send_word(32'h5555_0001 + 32'(i), i == 0, 1'b0);
    send_frame(32'h5555_0100, 3, 1'b1);
    exp_drop++;
    exp_ok++;
    drain("trunc_drain");
    check_counts("trunc");

    // Reset after word 2 of a frame, then a clean frame.
    send_word(32'h6666_0001, 1'b1, 1'b0);
    send_word(32'h6666_0002, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    reset     = 1'b0;
    drop_seen = 0;
    exp_ok    = 0;
    exp_drop  = 0;
    send_frame(32'h6666_0100, 4, 1'b1);
    exp_ok++;
    drain("postreset_drain");
    check_counts("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
